// File: rtl/ub_port_arbiter.sv
// Unified-buffer port arbiter: two writers, two readers onto one SDP BRAM.
// Ports: clk/reset, w0/w1 {valid,ready,addr,data,lock}, r0/r1 {valid,ready,addr,lock},
//        rd_{valid,id,data} read return, bram_{wea,addra,dina,enb,addrb,doutb} BRAM side.
module ub_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  input  logic                  w0_lock,
  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  input  logic                  w1_lock,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r0_lock,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic                  r1_lock,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_doutb
);

  logic w_owned, w_owner, w_last;
  logic r_owned, r_owner, r_last;

  logic [1:0]            w_req, w_gnt;
  logic [1:0]            r_req, r_gnt;
  logic                  w_fire, w_id, w_lk;
  logic                  r_fire, r_id, r_lk;
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  hz0, hz1;

  // Write side
  always_comb begin
    w_req = {w1_valid, w0_valid} & {2{~reset}};
    if (w_owned)
      w_gnt = w_req & (w_owner ? 2'b10 : 2'b01);
    else if (&w_req)
      w_gnt = w_last ? 2'b01 : 2'b10;
    else
      w_gnt = w_req;
  end

  assign w_fire = |w_gnt;
  assign w_id   = w_gnt[1];
  assign w_addr = w_id ? w1_addr : w0_addr;
  assign w_data = w_id ? w1_data : w0_data;
  assign w_lk   = w_id ? w1_lock : w0_lock;

  // A read colliding with this cycle's write is masked before
  // arbitration, so the other reader may still use the slot.
  assign hz0 = w_fire && (r0_addr == w_addr);
  assign hz1 = w_fire && (r1_addr == w_addr);

  // Read side
  always_comb begin
    r_req = {r1_valid & ~hz1, r0_valid & ~hz0} & {2{~reset}};
    if (r_owned)
      r_gnt = r_req & (r_owner ? 2'b10 : 2'b01);
    else if (&r_req)
      r_gnt = r_last ? 2'b01 : 2'b10;
    else
      r_gnt = r_req;
  end

  assign r_fire = |r_gnt;
  assign r_id   = r_gnt[1];
  assign r_addr = r_id ? r1_addr : r0_addr;
  assign r_lk   = r_id ? r1_lock : r0_lock;

  assign w0_ready = w_gnt[0];
  assign w1_ready = w_gnt[1];
  assign r0_ready = r_gnt[0];
  assign r1_ready = r_gnt[1];

  assign bram_wea   = w_fire;
  assign bram_addra = w_fire ? w_addr : '0;
  assign bram_dina  = w_fire ? w_data : '0;
  assign bram_enb   = r_fire;
  assign bram_addrb = r_fire ? r_addr : '0;

  // last=1 after reset so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_owned  <= 1'b0;
      w_owner  <= 1'b0;
      w_last   <= 1'b1;
      r_owned  <= 1'b0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      rd_valid <= 1'b0;
      rd_id    <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (w_fire) begin
        w_owned <= w_lk;
        w_owner <= w_id;
        w_last  <= w_id;
      end
      if (r_fire) begin
        r_owned <= r_lk;
        r_owner <= r_id;
        r_last  <= r_id;
        rd_id   <= r_id;
        // BRAM read happened on the negedge of this cycle.
        rd_data <= bram_doutb;
      end
      rd_valid <= r_fire;
    end
  end

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Directed self-checking bench for ub_port_arbiter.
// Includes a negedge BRAM model on the BRAM-side ports.
module tb_ub_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          w0_valid, w0_ready, w0_lock;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_data;
  logic          w1_valid, w1_ready, w1_lock;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_data;
  logic          r0_valid, r0_ready, r0_lock;
  logic [AW-1:0] r0_addr;
  logic          r1_valid, r1_ready, r1_lock;
  logic [AW-1:0] r1_addr;
  logic          rd_valid, rd_id;
  logic [DW-1:0] rd_data;
  logic          bram_wea, bram_enb;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [DW-1:0] bram_dina;
  logic [DW-1:0] bram_doutb = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  logic [3:0] rdy;
  assign rdy = {w0_ready, w1_ready, r0_ready, r1_ready};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  ub_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr),
    .w0_data(w0_data), .w0_lock(w0_lock),
    .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr),
    .w1_data(w1_data), .w1_lock(w1_lock),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
    .r0_lock(r0_lock),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
    .r1_lock(r1_lock),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  task automatic idle();
    w0_valid = 0; w0_lock = 0; w0_addr = '0; w0_data = '0;
    w1_valid = 0; w1_lock = 0; w1_addr = '0; w1_data = '0;
    r0_valid = 0; r0_lock = 0; r0_addr = '0;
    r1_valid = 0; r1_lock = 0; r1_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    w0_valid = 1; w1_valid = 1; r0_valid = 1; r1_valid = 1;
    r0_addr = 8'h40; r1_addr = 8'h41;
    tick();
    tick();
    #1;
    checks++;
    if (rdy !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got %b want 0000", rdy);
    end
    checks++;
    if ({bram_wea, bram_enb} !== 2'b00) begin
      errors++;
      $display("FAIL reset_bram got %b want 00", {bram_wea, bram_enb});
    end
    checks++;
    if ({rd_valid, rd_id} !== 2'b00 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rd got v%b id%b %h want 0 0 0",
               rd_valid, rd_id, rd_data);
    end
    tick();
    reset = 0;
    idle();
  endtask

  task automatic test_write_rr();
    logic [3:0] exp;
    w0_valid = 1; w0_addr = 8'hF0; w0_data = {16{8'hF0}};
    w1_valid = 1; w1_addr = 8'hF1; w1_data = {16{8'hF1}};
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = (i % 2 == 0) ? 4'b1000 : 4'b0100;
      checks++;
      if (rdy !== exp) begin
        errors++;
        $display("FAIL write_rr[%0d] got %b want %b", i, rdy, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_write_read();
    w0_valid = 1; w0_addr = 8'h10; w0_data = {16{8'hAA}};
    #1;
    checks++;
    if (rdy !== 4'b1000 || bram_wea !== 1'b1 || bram_addra !== 8'h10) begin
      errors++;
      $display("FAIL wr_accept got %b wea%b a%h want 1000 1 10",
               rdy, bram_wea, bram_addra);
    end
    tick();
    idle();
    r1_valid = 1; r1_addr = 8'h10;
    #1;
    checks++;
    if (rdy !== 4'b0001 || bram_enb !== 1'b1 || bram_addrb !== 8'h10) begin
      errors++;
      $display("FAIL rd_accept got %b enb%b a%h want 0001 1 10",
               rdy, bram_enb, bram_addrb);
    end
    tick();
    idle();
    checks++;
    if (rd_valid !== 1'b1 || rd_id !== 1'b1 || rd_data !== {16{8'hAA}}) begin
      errors++;
      $display("FAIL rd_return got v%b id%b %h want 1 1 aa..",
               rd_valid, rd_id, rd_data);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_onecycle got %b want 0", rd_valid);
    end
  endtask

  task automatic test_raw_hazard();
    w1_valid = 1; w1_addr = 8'h20; w1_data = {16{8'h55}};
    r0_valid = 1; r0_addr = 8'h20;
    #1;
    checks++;
    if (rdy !== 4'b0100) begin
      errors++;
      $display("FAIL raw_hold got %b want 0100", rdy);
    end
    tick();
    w1_valid = 0;
    #1;
    checks++;
    if (rdy !== 4'b0010) begin
      errors++;
      $display("FAIL raw_grant got %b want 0010", rdy);
    end
    tick();
    idle();
    checks++;
    if (rd_valid !== 1'b1 || rd_id !== 1'b0 || rd_data !== {16{8'h55}}) begin
      errors++;
      $display("FAIL raw_data got v%b id%b %h want 1 0 55..",
               rd_valid, rd_id, rd_data);
    end
  endtask

  task automatic test_read_lock();
    logic       v0 [0:5];
    logic       l0 [0:5];
    logic [3:0] exp [0:5];
    v0 = '{0, 1, 1, 0, 1, 1};
    l0 = '{0, 1, 1, 0, 1, 0};
    exp = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
    r0_addr = 8'h20;
    r1_addr = 8'h10;
    r1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      r0_valid = v0[i];
      r0_lock = l0[i];
      #1;
      checks++;
      if (rdy !== exp[i]) begin
        errors++;
        $display("FAIL read_lock[%0d] got %b want %b", i, rdy, exp[i]);
      end
      if (i == 2) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_id !== 1'b0 || rd_data !== {16{8'h55}}) begin
          errors++;
          $display("FAIL lock_data got v%b id%b %h want 1 0 55..",
                   rd_valid, rd_id, rd_data);
        end
      end
      if (i == 4) begin
        checks++;
        if (rd_valid !== 1'b0) begin
          errors++;
          $display("FAIL lock_idle got %b want 0", rd_valid);
        end
      end
      tick();
    end
    r0_valid = 0;
    #1;
    checks++;
    if (rdy !== 4'b0001) begin
      errors++;
      $display("FAIL lock_release got %b want 0001", rdy);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_burst();
    w1_valid = 1; w1_lock = 1; w1_addr = 8'h30; w1_data = {16{8'h33}};
    r0_valid = 1; r0_addr = 8'h10;
    #1;
    checks++;
    if (rdy !== 4'b0110) begin
      errors++;
      $display("FAIL burst_start got %b want 0110", rdy);
    end
    tick();
    reset = 1;
    w0_valid = 1; w0_addr = 8'h31; w0_data = {16{8'h31}};
    #1;
    checks++;
    if (rdy !== 4'b0000 || {bram_wea, bram_enb} !== 2'b00) begin
      errors++;
      $display("FAIL reset_gate got %b %b want 0000 00",
               rdy, {bram_wea, bram_enb});
    end
    tick();
    reset = 0;
    r0_valid = 0;
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_squash got %b want 0", rd_valid);
    end
    checks++;
    if (rdy !== 4'b1000) begin
      errors++;
      $display("FAIL reset_owner got %b want 1000", rdy);
    end
    tick();
    idle();
  endtask

  task automatic test_diff_addr();
    w0_valid = 1; w0_addr = 8'h06; w0_data = {16{8'h66}};
    #1;
    tick();
    w0_addr = 8'h05; w0_data = {16{8'h11}};
    r0_valid = 1; r0_addr = 8'h06;
    #1;
    checks++;
    if (rdy !== 4'b1010) begin
      errors++;
      $display("FAIL diff_both got %b want 1010", rdy);
    end
    tick();
    idle();
    checks++;
    if (rd_valid !== 1'b1 || rd_id !== 1'b0 || rd_data !== {16{8'h66}}) begin
      errors++;
      $display("FAIL diff_data got v%b id%b %h want 1 0 66..",
               rd_valid, rd_id, rd_data);
    end
    r1_valid = 1; r1_addr = 8'h05;
    #1;
    tick();
    idle();
    checks++;
    if (rd_valid !== 1'b1 || rd_id !== 1'b1 || rd_data !== {16{8'h11}}) begin
      errors++;
      $display("FAIL diff_wr got v%b id%b %h want 1 1 11..",
               rd_valid, rd_id, rd_data);
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_write_rr();
    test_write_read();
    test_raw_hazard();
    test_read_lock();
    test_reset_mid_burst();
    test_diff_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
